pulse_sync_feeder: RTL and testbench
====================================

Name: pulse_sync_feeder

Overview:
- Source-domain (clk1) front end for the handshake pulse synchronizer.
- Accepts single-cycle event pulses at any rate, including back-to-back, and counts them as pending.
- Releases them one at a time on sync_in, only when the synchronizer is idle (busy low), so no event is lost to a busy handshake.
- Flags overflow when more events arrive than the pending counter can hold.

Parameters:
CNT_W, 4, pending counter width; max pending = 2^CNT_W-1 (15)
MIN_GAP, 1, idle clk1 cycles forced after busy falls before next issue (0 allowed)
BUSY_WAIT, 4, max clk1 cycles to wait for busy to rise after an issue

Ports:
clk1  input  1  source-domain clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
evt_in  input  1  event pulse, one event per high cycle
sync_busy  input  1  busy from handshake synchronizer (clk1 domain)
clr_ovf  input  1  clears overflow sticky flag
sync_in  output  1  single-cycle pulse to synchronizer input
pending_cnt  output  CNT_W  events accepted but not yet issued
overflow  output  1  sticky: an event was dropped
busy_tmo  output  1  sticky: busy never rose within BUSY_WAIT after an issue
idle  output  1  high when FSM in IDLE and pending_cnt==0

Behaviour:
- Reset (sync, active-high): sync_in=0, pending_cnt=0, overflow=0, busy_tmo=0, FSM=IDLE, gap counter=0, idle=1. Reset overrides all inputs.
- Counter, per cycle:
  - inc = evt_in && !(pending_cnt==MAX && !dec); dec = issue this cycle.
  - inc&&dec -> unchanged; inc only -> +1; dec only -> -1.
  - evt_in at MAX with no dec -> event dropped, overflow<=1.
  - Never wraps, never underflows.
- overflow: clr_ovf clears it. Same-cycle drop and clr_ovf -> overflow=1 (set wins).
- FSM states: IDLE, WAIT_BUSY, WAIT_DONE, GAP.
  - IDLE: if pending_cnt>0 && !sync_busy -> issue: sync_in<=1 for exactly one cycle, dec, go WAIT_BUSY with timer=0.
  - Issue decision uses registered pending_cnt. An event arriving when pending_cnt==0 issues the following cycle: evt_in@N -> pending_cnt=1@N+1 -> sync_in high in cycle N+2.
  - WAIT_BUSY: sync_busy==1 -> WAIT_DONE. Otherwise timer++. When timer reaches BUSY_WAIT with no busy -> busy_tmo<=1, go GAP (event counted as delivered; not re-issued).
  - WAIT_DONE: sync_busy==0 -> GAP (or IDLE if MIN_GAP==0).
  - GAP: hold MIN_GAP cycles, then IDLE.
- sync_in: registered, high only on the cycle following the issue decision. Never high in two consecutive cycles. Never high while state != IDLE-derived issue.
- sync_busy high while in IDLE: no issue; pending accumulates.
- busy_tmo: cleared only by reset.
- Mid-operation reset: all state discarded, pending events lost, sync_in deasserted the next cycle.
- idle is combinational from registered state.

Optional Feature:
- Macro PULSE_SYNC_FEEDER_DROP_CNT_EN.
- Defined: adds output drop_cnt [7:0]. Increments on every dropped event, saturates at 255, cleared by reset or clr_ovf. clr_ovf and a drop in the same cycle -> drop_cnt=1.
- Undefined: port and logic absent. overflow behaviour unchanged.

Test Plan:
- Single event: reset 2 cycles, evt_in pulse @N, sync_busy modelled as high 3 cycles starting 1 cycle after sync_in -> sync_in high only in cycle N+2; pending_cnt 0->1->0; idle returns 1 after busy falls + MIN_GAP.
- Burst: 5 back-to-back evt_in cycles, synchronizer model busy 6 cycles per pulse -> exactly 5 sync_in pulses, each separated by busy-low + 1 gap cycle; pending_cnt peaks at 4 or 5 (depending on first issue overlap), ends 0; overflow=0.
- Overflow: hold sync_busy=1, drive 17 evt_in pulses -> pending_cnt saturates at 15, overflow=1 (drop_cnt=2 when macro enabled). clr_ovf -> overflow=0. Release busy -> 15 pulses issued.
- Simultaneous inc/dec: pending_cnt=3, evt_in high on the issue cycle -> pending_cnt stays 3.
- Timeout: sync_busy tied 0, one event -> one sync_in pulse; busy_tmo=1 after 4 cycles; no re-issue; pending_cnt=0.
- Reset mid-burst: pending_cnt=6 in WAIT_DONE, assert reset 1 cycle -> next cycle pending_cnt=0, sync_in=0, overflow=0, idle=1; no further pulses.

Source files
------------

// File: rtl/pulse_sync_feeder_if.sv
// rtl/pulse_sync_feeder_if.sv - event/handshake/status bundle for pulse_sync_feeder (drop_cnt under PULSE_SYNC_FEEDER_DROP_CNT_EN)
interface pulse_sync_feeder_if #(
    parameter int CNT_W = 4
);
    logic             evt_in;
    logic             sync_busy;
    logic             clr_ovf;
    logic             sync_in;
    logic [CNT_W-1:0] pending_cnt;
    logic             overflow;
    logic             busy_tmo;
    logic             idle;
`ifdef PULSE_SYNC_FEEDER_DROP_CNT_EN
    logic [7:0]       drop_cnt;

    modport master (
        input  evt_in, sync_busy, clr_ovf,
        output sync_in, pending_cnt, overflow, busy_tmo, idle, drop_cnt
    );
    modport slave (
        output evt_in, sync_busy, clr_ovf,
        input  sync_in, pending_cnt, overflow, busy_tmo, idle, drop_cnt
    );
`else
    modport master (
        input  evt_in, sync_busy, clr_ovf,
        output sync_in, pending_cnt, overflow, busy_tmo, idle
    );
    modport slave (
        output evt_in, sync_busy, clr_ovf,
        input  sync_in, pending_cnt, overflow, busy_tmo, idle
    );
`endif
endinterface

// File: rtl/pulse_sync_feeder.sv
// rtl/pulse_sync_feeder.sv - clk1 event counter and one-at-a-time issuer for the pulse synchronizer (optional PULSE_SYNC_FEEDER_DROP_CNT_EN)
module pulse_sync_feeder #(
    parameter int CNT_W     = 4,
    parameter int MIN_GAP   = 1,
    parameter int BUSY_WAIT = 4
) (
    input  logic                  clk1,
    input  logic                  reset,
    pulse_sync_feeder_if.master   bus
);
    localparam int TMR_W = (BUSY_WAIT < 2) ? 1 : $clog2(BUSY_WAIT + 1);
    localparam int GAP_W = (MIN_GAP < 2) ? 1 : $clog2(MIN_GAP + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((BUSY_WAIT > 0) ? BUSY_WAIT - 1 : 0);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_GAP
    } state_t;

    // With no gap configured the handshake returns straight to IDLE.
    localparam state_t ST_POST = (MIN_GAP == 0) ? ST_IDLE : ST_GAP;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] pending_cnt_q, pending_cnt_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             sync_in_q, sync_in_d;
    logic             overflow_q, overflow_d;
    logic             busy_tmo_q, busy_tmo_d;
    logic             issue, drop, inc;
`ifdef PULSE_SYNC_FEEDER_DROP_CNT_EN
    logic [7:0]       drop_cnt_q, drop_cnt_d;
`endif

    always_comb begin
        issue         = 1'b0;
        drop          = 1'b0;
        inc           = 1'b0;
        state_d       = state_q;
        pending_cnt_d = pending_cnt_q;
        timer_d       = timer_q;
        gap_d         = gap_q;
        overflow_d    = overflow_q;
        busy_tmo_d    = busy_tmo_q;

        issue = (state_q == ST_IDLE) && (pending_cnt_q != '0) && !bus.sync_busy;
        // A full counter still accepts an event when an issue frees a slot.
        drop  = bus.evt_in && (pending_cnt_q == CNT_MAX) && !issue;
        inc   = bus.evt_in && !drop;

        if (inc && !issue) begin
            pending_cnt_d = pending_cnt_q + CNT_W'(1);
        end else if (!inc && issue) begin
            pending_cnt_d = pending_cnt_q - CNT_W'(1);
        end

        if (drop) begin
            overflow_d = 1'b1;
        end else if (bus.clr_ovf) begin
            overflow_d = 1'b0;
        end

        sync_in_d = issue;

        case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    state_d = ST_WAIT_BUSY;
                    timer_d = '0;
                end
            end
            ST_WAIT_BUSY: begin
                if (bus.sync_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (timer_q == TMR_LAST) begin
                    busy_tmo_d = 1'b1;
                    state_d    = ST_POST;
                    gap_d      = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.sync_busy) begin
                    state_d = ST_POST;
                    gap_d   = '0;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef PULSE_SYNC_FEEDER_DROP_CNT_EN
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (bus.clr_ovf) begin
            drop_cnt_d = drop ? 8'd1 : 8'd0;
        end else if (drop && (drop_cnt_q != 8'd255)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk1) begin
        if (reset) begin
            drop_cnt_q <= 8'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.drop_cnt = drop_cnt_q;
`endif

    always_ff @(posedge clk1) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pending_cnt_q <= '0;
            timer_q       <= '0;
            gap_q         <= '0;
            sync_in_q     <= 1'b0;
            overflow_q    <= 1'b0;
            busy_tmo_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_cnt_q <= pending_cnt_d;
            timer_q       <= timer_d;
            gap_q         <= gap_d;
            sync_in_q     <= sync_in_d;
            overflow_q    <= overflow_d;
            busy_tmo_q    <= busy_tmo_d;
        end
    end

    assign bus.sync_in     = sync_in_q;
    assign bus.pending_cnt = pending_cnt_q;
    assign bus.overflow    = overflow_q;
    assign bus.busy_tmo    = busy_tmo_q;
    assign bus.idle        = (state_q == ST_IDLE) && (pending_cnt_q == '0);
endmodule

// File: tb/tb_pulse_sync_feeder.sv
// tb/tb_pulse_sync_feeder.sv - directed vector and sequence bench for pulse_sync_feeder
module tb_pulse_sync_feeder;
    logic clk1;
    logic reset;

    pulse_sync_feeder_if #(.CNT_W(4)) bus ();

    pulse_sync_feeder #(
        .CNT_W    (4),
        .MIN_GAP  (1),
        .BUSY_WAIT(4)
    ) dut (
        .clk1 (clk1),
        .reset(reset),
        .bus  (bus)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    typedef struct packed {
        logic       rst;
        logic       evt;
        logic       busy;
        logic       clr;
        logic       e_sync;
        logic [3:0] e_pend;
        logic       e_ovf;
        logic       e_tmo;
        logic       e_idle;
    } vec_t;

    localparam int NV = 19;
    vec_t vt[NV];

    int checks;
    int failures;
    int cyc;
    int pulses;
    int consec;
    int peak;
    int rem;
    int busy_len;
    int n;
    bit model_en;
    bit prev_sync;
    int pulse_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance to the next falling edge; optionally model the synchronizer busy
    // (high busy_len cycles starting the cycle after sync_in) and log pulses.
    task automatic tick();
        @(negedge clk1);
        cyc++;
        if (model_en) begin
            if (prev_sync) rem = busy_len;
            bus.sync_busy = (rem > 0);
            if (rem > 0) rem--;
        end
        if (bus.sync_in) begin
            if (prev_sync) consec++;
            pulses++;
            pulse_q.push_back(cyc);
        end
        if (int'(bus.pending_cnt) > peak) peak = int'(bus.pending_cnt);
        prev_sync = bus.sync_in;
    endtask

    function automatic vec_t mk(input logic r, e, b, c, s, input logic [3:0] p, input logic o, t, i);
        vec_t v;
        v = '{rst: r, evt: e, busy: b, clr: c, e_sync: s, e_pend: p, e_ovf: o, e_tmo: t, e_idle: i};
        return v;
    endfunction

    initial begin
        checks = 0; failures = 0; cyc = 0; pulses = 0; consec = 0; peak = 0;
        rem = 0; busy_len = 0; model_en = 0; prev_sync = 0;
        reset = 1'b1;
        bus.evt_in = 1'b0; bus.sync_busy = 1'b0; bus.clr_ovf = 1'b0;

        //           rst evt bsy clr | sync pend ovf tmo idle  (outputs after this row's edge)
        vt[0]  = mk(1, 0, 0, 0,   0, 4'd0, 0, 0, 1);
        vt[1]  = mk(0, 1, 0, 0,   0, 4'd1, 0, 0, 0);
        vt[2]  = mk(0, 0, 0, 0,   1, 4'd0, 0, 0, 0);
        vt[3]  = mk(0, 0, 1, 0,   0, 4'd0, 0, 0, 0);
        vt[4]  = mk(0, 1, 1, 0,   0, 4'd1, 0, 0, 0);
        vt[5]  = mk(0, 0, 0, 0,   0, 4'd1, 0, 0, 0);
        vt[6]  = mk(0, 0, 0, 0,   0, 4'd1, 0, 0, 0);
        vt[7]  = mk(0, 0, 0, 0,   1, 4'd0, 0, 0, 0);
        vt[8]  = mk(0, 0, 0, 0,   0, 4'd0, 0, 0, 0);
        vt[9]  = mk(0, 0, 0, 0,   0, 4'd0, 0, 0, 0);
        vt[10] = mk(0, 0, 0, 0,   0, 4'd0, 0, 0, 0);
        vt[11] = mk(0, 0, 0, 0,   0, 4'd0, 0, 1, 0);
        vt[12] = mk(0, 0, 0, 0,   0, 4'd0, 0, 1, 1);
        vt[13] = mk(0, 1, 1, 0,   0, 4'd1, 0, 1, 0);
        vt[14] = mk(0, 1, 1, 0,   0, 4'd2, 0, 1, 0);
        vt[15] = mk(0, 1, 1, 0,   0, 4'd3, 0, 1, 0);
        vt[16] = mk(0, 1, 0, 0,   1, 4'd3, 0, 1, 0);
        vt[17] = mk(1, 1, 0, 0,   0, 4'd0, 0, 0, 1);
        vt[18] = mk(0, 0, 0, 0,   0, 4'd0, 0, 0, 1);

        tick();
        tick();
`ifdef PULSE_SYNC_FEEDER_DROP_CNT_EN
        chk("reset_drop_cnt", bus.drop_cnt, 0);
`endif

        for (int i = 0; i <= NV; i++) begin
            if (i > 0) begin
                chk($sformatf("vec%0d_sync_in", i - 1), bus.sync_in, vt[i-1].e_sync);
                chk($sformatf("vec%0d_pending", i - 1), bus.pending_cnt, vt[i-1].e_pend);
                chk($sformatf("vec%0d_overflow", i - 1), bus.overflow, vt[i-1].e_ovf);
                chk($sformatf("vec%0d_busy_tmo", i - 1), bus.busy_tmo, vt[i-1].e_tmo);
                chk($sformatf("vec%0d_idle", i - 1), bus.idle, vt[i-1].e_idle);
            end
            if (i < NV) begin
                reset         = vt[i].rst;
                bus.evt_in    = vt[i].evt;
                bus.sync_busy = vt[i].busy;
                bus.clr_ovf   = vt[i].clr;
                tick();
            end
        end
        reset = 1'b0; bus.evt_in = 1'b0; bus.sync_busy = 1'b0;

        // Burst of 5 with a 6-cycle synchronizer: pulses every 10 cycles.
        reset = 1'b1; tick(); reset = 1'b0;
        busy_len = 6; rem = 0; model_en = 1;
        pulses = 0; consec = 0; peak = 0; pulse_q.delete();
        for (int k = 0; k < 5; k++) begin
            bus.evt_in = 1'b1;
            tick();
        end
        bus.evt_in = 1'b0;
        n = 0;
        while (!(pulses == 5 && bus.idle) && n < 300) begin
            tick();
            n++;
        end
        chk("burst_done_in_time", (n < 300), 1);
        chk("burst_pulses", pulses, 5);
        chk("burst_peak_pending", peak, 4);
        chk("burst_end_pending", bus.pending_cnt, 0);
        chk("burst_overflow", bus.overflow, 0);
        chk("burst_back_to_back", consec, 0);
        for (int j = 1; j < pulse_q.size(); j++) begin
            chk($sformatf("burst_spacing%0d", j), pulse_q[j] - pulse_q[j-1], 10);
        end

        // Overflow with busy held high, then drain.
        reset = 1'b1; tick(); reset = 1'b0;
        model_en = 0; bus.sync_busy = 1'b1; pulses = 0;
        for (int k = 0; k < 17; k++) begin
            bus.evt_in = 1'b1;
            tick();
        end
        bus.evt_in = 1'b0;
        chk("ovf_pending_sat", bus.pending_cnt, 15);
        chk("ovf_flag", bus.overflow, 1);
        chk("ovf_no_issue", pulses, 0);
`ifdef PULSE_SYNC_FEEDER_DROP_CNT_EN
        chk("ovf_drop_cnt", bus.drop_cnt, 2);
`endif
        bus.evt_in = 1'b1; bus.clr_ovf = 1'b1;
        tick();
        bus.evt_in = 1'b0; bus.clr_ovf = 1'b0;
        chk("ovf_set_wins", bus.overflow, 1);
        chk("ovf_set_wins_pending", bus.pending_cnt, 15);
`ifdef PULSE_SYNC_FEEDER_DROP_CNT_EN
        chk("ovf_drop_cnt_clr_drop", bus.drop_cnt, 1);
`endif
        bus.clr_ovf = 1'b1;
        tick();
        bus.clr_ovf = 1'b0;
        chk("ovf_cleared", bus.overflow, 0);
`ifdef PULSE_SYNC_FEEDER_DROP_CNT_EN
        chk("ovf_drop_cnt_cleared", bus.drop_cnt, 0);
`endif
        busy_len = 2; rem = 0; model_en = 1; consec = 0;
        n = 0;
        while (!(pulses == 15 && bus.idle) && n < 600) begin
            tick();
            n++;
        end
        chk("drain_done_in_time", (n < 600), 1);
        chk("drain_pulses", pulses, 15);
        chk("drain_pending", bus.pending_cnt, 0);
        chk("drain_no_tmo", bus.busy_tmo, 0);
        chk("drain_back_to_back", consec, 0);

        // Reset while waiting for busy to fall with 6 events pending.
        reset = 1'b1; tick(); reset = 1'b0;
        busy_len = 6; rem = 0; model_en = 1;
        for (int k = 0; k < 7; k++) begin
            bus.evt_in = 1'b1;
            tick();
        end
        bus.evt_in = 1'b0;
        chk("midrst_pending_before", bus.pending_cnt, 6);
        chk("midrst_idle_before", bus.idle, 0);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("midrst_pending", bus.pending_cnt, 0);
        chk("midrst_sync_in", bus.sync_in, 0);
        chk("midrst_overflow", bus.overflow, 0);
        chk("midrst_idle", bus.idle, 1);
        pulses = 0;
        repeat (30) tick();
        chk("midrst_no_pulses", pulses, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
